seq_divider: RTL and testbench

//   Sequential unsigned integer divider. Radix-2 restoring algorithm, one quotient bit per clock.

---
 rtl/seq_divider.sv | 110 +++++++++++
 tb/tb_seq_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned divider, radix-2 restoring, one quotient bit per clock.
// Operands are captured while READY_I is high. The division runs after READY_I falls,
// and the result registers update only on the edge that completes the last step.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no division in flight, outputs hold the last result
// LOAD  | operands captured (READY_I high), partial remainder cleared
// RUN   | one restoring step per edge until the counter expires
module seq_divider #(
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    READY_I,
    input  logic [PAYLOAD_BITS-1:0] DIVIDENT_I,
    input  logic [PAYLOAD_BITS-1:0] DIVISOR_I,
    output logic [PAYLOAD_BITS-1:0] QUOTIENT_O,
    output logic [PAYLOAD_BITS-1:0] REMINDER_O
);

    localparam int W  = PAYLOAD_BITS;
    localparam int CW = $clog2(PAYLOAD_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    q_q, q_d;        // dividend shift reg, becomes the quotient
    logic [W-1:0]    d_q, d_d;        // divisor
    logic [W:0]      r_q, r_d;        // partial remainder
    logic [CW-1:0]   cnt_q, cnt_d;    // steps still to perform
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    rem_q, rem_d;

    logic [W:0]      r_sh;
    logic [W+1:0]    diff;
    logic [W:0]      r_step;
    logic [W-1:0]    q_step;
    logic            unused_r_msb;

    // The partial remainder never exceeds W bits between steps, so its top bit is
    // only a guard and does not feed the next shift.
    assign unused_r_msb = r_q[W];

    // One restoring step: shift {R,Q} left, trial-subtract D, keep the result if non-negative.
    always_comb begin
        r_sh   = {r_q[W-1:0], q_q[W-1]};
        diff   = {1'b0, r_sh} - {2'b00, d_q};
        r_step = diff[W+1] ? r_sh : diff[W:0];
        q_step = {q_q[W-2:0], ~diff[W+1]};
    end

    // Next-state logic: READY_I high always (re)loads; otherwise step until the counter expires.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        if (READY_I) begin
            state_d = ST_LOAD;
            q_d     = DIVIDENT_I;
            d_d     = DIVISOR_I;
            r_d     = '0;
            cnt_d   = CW'(W);
        end else if (state_q != ST_IDLE) begin
            q_d   = q_step;
            r_d   = r_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                quot_d  = q_step;
                rem_d   = r_step[W-1:0];
                state_d = ST_IDLE;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    // State and result registers; reset aborts any division and clears the outputs at once.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign QUOTIENT_O = quot_q;
    assign REMINDER_O = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks for seq_divider at PAYLOAD_BITS=8 and PAYLOAD_BITS=4.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready8, ready4;
    logic [7:0] a8, b8, q8, r8;
    logic [3:0] a4, b4, q4, r4;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] last_q, last_r;

    always #5 clk = ~clk;

    seq_divider #(.PAYLOAD_BITS(8)) u_dut8 (
        .CLK_I      (clk),
        .RST_I      (rst),
        .READY_I    (ready8),
        .DIVIDENT_I (a8),
        .DIVISOR_I  (b8),
        .QUOTIENT_O (q8),
        .REMINDER_O (r8)
    );

    seq_divider #(.PAYLOAD_BITS(4)) u_dut4 (
        .CLK_I      (clk),
        .RST_I      (rst),
        .READY_I    (ready4),
        .DIVIDENT_I (a4),
        .DIVISOR_I  (b4),
        .QUOTIENT_O (q4),
        .REMINDER_O (r4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Load a/b for 'hold' edges, then run; outputs must hold the old result through
    // seven run edges and show the new one after the eighth. Operands are scrambled
    // after the first run edge to show they are no longer sampled.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input logic [7:0] exp_q, input logic [7:0] exp_r);
        @(negedge clk);
        ready8 = 1'b1;
        a8 = a;
        b8 = b;
        repeat (hold) @(negedge clk);
        ready8 = 1'b0;
        @(negedge clk);
        a8 = ~a;
        b8 = b + 8'd3;
        repeat (6) @(negedge clk);
        check({tag, "_hold_q"}, 32'(q8), 32'(last_q));
        check({tag, "_hold_r"}, 32'(r8), 32'(last_r));
        @(negedge clk);
        check({tag, "_q"}, 32'(q8), 32'(exp_q));
        check({tag, "_r"}, 32'(r8), 32'(exp_r));
        last_q = exp_q;
        last_r = exp_r;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_q, input logic [3:0] exp_r);
        @(negedge clk);
        ready4 = 1'b1;
        a4 = a;
        b4 = b;
        @(negedge clk);
        ready4 = 1'b0;
        repeat (4) @(negedge clk);
        check($sformatf("w4_%0d_%0d_q", a, b), 32'(q4), 32'(exp_q));
        check($sformatf("w4_%0d_%0d_r", a, b), 32'(r4), 32'(exp_r));
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst    = 1'b1;
        ready8 = 1'b0;
        ready4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        last_q = '0;
        last_r = '0;
        #1;
        check("reset_q", 32'(q8), 0);
        check("reset_r", 32'(r8), 0);
        check("reset_q4", 32'(q4), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_q", 32'(q8), 0);

        run8("d200_255", 8'd200, 8'd255, 7, 8'd0, 8'd200);
        run8("d126_13", 8'd126, 8'd13, 7, 8'd9, 8'd9);
        repeat (5) @(negedge clk);
        check("idle_hold_q", 32'(q8), 9);
        check("idle_hold_r", 32'(r8), 9);
        run8("d255_1", 8'd255, 8'd1, 1, 8'd255, 8'd0);
        run8("d255_0", 8'd255, 8'd0, 2, 8'd255, 8'd255);
        run8("d7_7", 8'd7, 8'd7, 1, 8'd1, 8'd0);
        run8("d0_5", 8'd0, 8'd5, 1, 8'd0, 8'd0);

        // Abort: 126/13 is replaced by 100/7 after three run edges.
        @(negedge clk);
        ready8 = 1'b1; a8 = 8'd126; b8 = 8'd13;
        @(negedge clk);
        ready8 = 1'b0;
        repeat (3) @(negedge clk);
        ready8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        repeat (2) @(negedge clk);
        check("abort_load_q", 32'(q8), 32'(last_q));
        ready8 = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_hold_q", 32'(q8), 32'(last_q));
        check("abort_hold_r", 32'(r8), 32'(last_r));
        @(negedge clk);
        check("abort_q", 32'(q8), 14);
        check("abort_r", 32'(r8), 2);

        // Asynchronous reset in the middle of 126/13, away from any clock edge.
        @(negedge clk);
        ready8 = 1'b1; a8 = 8'd126; b8 = 8'd13;
        @(negedge clk);
        ready8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_q", 32'(q8), 0);
        check("midrun_rst_r", 32'(r8), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("after_rst_q", 32'(q8), 0);
        check("after_rst_r", 32'(r8), 0);
        last_q = '0;
        last_r = '0;

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255, 1));
            run8($sformatf("rnd_%0d_%0d", ra, rb), ra, rb, 1, ra / rb, ra % rb);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run4(4'(a), 4'(b), 4'(a / b), 4'(a % b));
            end
        end
        run4(4'd9, 4'd0, 4'd15, 4'd9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
